// File: rtl/minmax_session_arbiter_if.sv
// Bundles the sample-source and result ports of the min/max session arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// whatever drives the sample sources and consumes the results.
interface minmax_session_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 5,
    parameter int ID_W  = 2
) ();

    // Sample sources: one lane per requester.
    logic [NREQ-1:0]   REQ_VALID;
    logic [NREQ-1:0]   REQ_LAST;
    logic [NREQ*8-1:0] REQ_DATA;
    logic [NREQ-1:0]   REQ_READY;
    logic [NREQ-1:0]   GRANT;
    logic              BUSY;

    // Result port.
    logic              RES_VALID;
    logic              RES_READY;
    logic [ID_W-1:0]   RES_ID;
    logic [7:0]        RES_MAX;
    logic [7:0]        RES_MIN;
    logic [7:0]        RES_MID;
    logic [LEN_W-1:0]  RES_COUNT;

    modport slave (
        input  REQ_VALID, REQ_LAST, REQ_DATA, RES_READY,
        output REQ_READY, GRANT, BUSY,
        output RES_VALID, RES_ID, RES_MAX, RES_MIN, RES_MID, RES_COUNT
    );

    modport master (
        output REQ_VALID, REQ_LAST, REQ_DATA, RES_READY,
        input  REQ_READY, GRANT, BUSY,
        input  RES_VALID, RES_ID, RES_MAX, RES_MIN, RES_MID, RES_COUNT
    );

endinterface

// File: rtl/minmax_session_arbiter.sv
// Round-robin arbiter that gives one signed min/max/midpoint statistics engine
// to NREQ sample sources. The granted source streams signed 8-bit samples as a
// session. A session ends on LAST or after MAX_LEN beats. The session's max,
// min, floor midpoint and beat count then go out on a valid/ready result port.
module minmax_session_arbiter #(
    parameter int NREQ    = 4,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int ID_W    = 2
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    minmax_session_arbiter_if.slave   bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] REPORT  = 2'd2;

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NREQ - 1);

    // Session state.
    logic [1:0]        state_r;
    logic [ID_W-1:0]   ptr_r;
    logic [ID_W-1:0]   win_r;
    logic [NREQ-1:0]   grant_r;
    logic [LEN_W-1:0]  count_r;
    logic [7:0]        max_r;
    logic [7:0]        min_r;

    // Registered result.
    logic              res_valid_r;
    logic [ID_W-1:0]   res_id_r;
    logic [7:0]        res_max_r;
    logic [7:0]        res_min_r;
    logic [7:0]        res_mid_r;
    logic [LEN_W-1:0]  res_count_r;

    // Arbitration and datapath helpers.
    logic              arb_found;
    logic [ID_W-1:0]   arb_idx;
    int                scan_idx;
    logic [NREQ-1:0]   req_ready;
    logic              beat_ok;
    logic [7:0]        sel_data;
    logic              sel_last;
    logic [7:0]        nxt_max;
    logic [7:0]        nxt_min;
    logic [8:0]        mid_sum;
    logic [7:0]        nxt_mid;
    logic [LEN_W-1:0]  count_inc;
    logic              close_session;
    logic [ID_W-1:0]   nxt_ptr;

    // Pick the first valid requester at or after the pointer, wrapping once.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        arb_found = 1'b0;
        arb_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(ptr_r) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!arb_found && bus.REQ_VALID[scan_idx]) begin
                arb_found = 1'b1;
                arb_idx   = ID_W'(scan_idx);
            end
        end
    end

    // Steer the winner's lane onto the shared datapath.
    always_comb begin
        sel_data = 8'h00;
        sel_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_r == ID_W'(i)) begin
                sel_data = bus.REQ_DATA[i*8 +: 8];
                sel_last = bus.REQ_LAST[i];
            end
        end
    end

    // Only the grant holder sees READY, and only while a session is collecting.
    assign req_ready = (state_r == COLLECT) ? grant_r : '0;
    assign beat_ok   = |(bus.REQ_VALID & req_ready);

    // Running extremes including the beat that is being accepted now.
    always_comb begin
        nxt_max = max_r;
        nxt_min = min_r;
        if (count_r == '0) begin
            nxt_max = sel_data;
            nxt_min = sel_data;
        end else if ($signed(sel_data) > $signed(max_r)) begin
            nxt_max = sel_data;
        end else if ($signed(sel_data) < $signed(min_r)) begin
            nxt_min = sel_data;
        end
    end

    // The 9-bit sum of two sign-extended bytes cannot overflow. Dropping its
    // LSB is an arithmetic shift right, so the midpoint rounds toward -inf.
    assign mid_sum       = {nxt_max[7], nxt_max} + {nxt_min[7], nxt_min};
    assign nxt_mid       = mid_sum[8:1];
    assign count_inc     = count_r + LEN_W'(1);
    assign close_session = sel_last || (count_inc == MAX_LEN_C);
    assign nxt_ptr       = (win_r == LAST_ID) ? '0 : win_r + ID_W'(1);

    // Session sequencer: IDLE grants, COLLECT accumulates, REPORT waits for the consumer.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            // NOTE: the result registers are reset too, because they drive outputs that must read zero after reset.
            state_r     <= IDLE;
            ptr_r       <= '0;
            win_r       <= '0;
            grant_r     <= '0;
            count_r     <= '0;
            max_r       <= 8'h00;
            min_r       <= 8'h00;
            res_valid_r <= 1'b0;
            res_id_r    <= '0;
            res_max_r   <= 8'h00;
            res_min_r   <= 8'h00;
            res_mid_r   <= 8'h00;
            res_count_r <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state_r)
                IDLE: begin
                    if (arb_found) begin
                        grant_r <= NREQ'(1) << arb_idx;
                        win_r   <= arb_idx;
                        count_r <= '0;
                        state_r <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (beat_ok) begin
                        max_r   <= nxt_max;
                        min_r   <= nxt_min;
                        count_r <= count_inc;
                        if (close_session) begin
                            state_r     <= REPORT;
                            res_valid_r <= 1'b1;
                            res_id_r    <= win_r;
                            res_max_r   <= nxt_max;
                            res_min_r   <= nxt_min;
                            res_mid_r   <= nxt_mid;
                            res_count_r <= count_inc;
                        end
                    end
                end
                REPORT: begin
                    if (bus.RES_READY) begin
                        res_valid_r <= 1'b0;
                        grant_r     <= '0;
                        ptr_r       <= nxt_ptr;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.REQ_READY = req_ready;
    assign bus.GRANT     = grant_r;
    assign bus.BUSY      = (state_r != IDLE);
    assign bus.RES_VALID = res_valid_r;
    assign bus.RES_ID    = res_id_r;
    assign bus.RES_MAX   = res_max_r;
    assign bus.RES_MIN   = res_min_r;
    assign bus.RES_MID   = res_mid_r;
    assign bus.RES_COUNT = res_count_r;

endmodule

// File: tb/tb_minmax_session_arbiter.sv
// Directed bench for minmax_session_arbiter. Expected results are worked out
// by hand from the sample sequences.
module tb_minmax_session_arbiter;

    localparam int NREQ    = 4;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int ID_W    = 2;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] beat_mem [0:NREQ-1][0:31];

    always #5 CLOCK = ~CLOCK;

    minmax_session_arbiter_if #(.NREQ(NREQ), .LEN_W(LEN_W), .ID_W(ID_W)) bus ();

    minmax_session_arbiter #(
        .NREQ(NREQ), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .ID_W(ID_W)
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .bus(bus)
    );

    // Structural properties that must hold on every cycle outside reset.
    always @(negedge CLOCK) begin
        if (!RESET) begin
            tests_run++;
            if (!$onehot0(bus.GRANT)) begin
                tests_failed++;
                $display("FAIL inv_grant_onehot: GRANT=%b, required one-hot or zero", bus.GRANT);
            end
            if (bus.RES_VALID) begin
                tests_run++;
                if (($signed(bus.RES_MIN) > $signed(bus.RES_MAX)) ||
                    (bus.RES_MAX[7] && !bus.RES_MIN[7]) ||
                    (bus.RES_COUNT == '0) || (int'(bus.RES_COUNT) > MAX_LEN)) begin
                    tests_failed++;
                    $display("FAIL inv_result: max=%h min=%h count=%0d, required min<=max and count in 1..%0d",
                             bus.RES_MAX, bus.RES_MIN, bus.RES_COUNT, MAX_LEN);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        RESET         = 1'b1;
        bus.REQ_VALID = '0;
        bus.REQ_LAST  = '0;
        bus.REQ_DATA  = '0;
        bus.RES_READY = 1'b0;
        repeat (2) @(posedge CLOCK);
        #1 RESET = 1'b0;
    endtask

    // Streams n beats from beat_mem[id]. LAST goes with the final beat if end_last is set.
    task automatic drive_session(input int id, input int n, input bit end_last);
        int k;
        int guard;
        k = 0;
        guard = 0;
        @(posedge CLOCK);
        #1;
        bus.REQ_VALID[id]        = 1'b1;
        bus.REQ_DATA[id*8 +: 8]  = beat_mem[id][0];
        bus.REQ_LAST[id]         = end_last && (n == 1);
        while (k < n && guard < 400) begin
            @(negedge CLOCK);
            guard++;
            if (bus.REQ_READY[id]) begin
                @(posedge CLOCK);
                #1;
                k++;
                if (k < n) begin
                    bus.REQ_DATA[id*8 +: 8] = beat_mem[id][k];
                    bus.REQ_LAST[id]        = end_last && (k == n - 1);
                end else begin
                    bus.REQ_VALID[id] = 1'b0;
                    bus.REQ_LAST[id]  = 1'b0;
                end
            end
        end
        tests_run++;
        if (k < n) begin
            tests_failed++;
            $display("FAIL drive_req%0d: accepted %0d beats, required %0d", id, k, n);
            bus.REQ_VALID[id] = 1'b0;
            bus.REQ_LAST[id]  = 1'b0;
        end
    endtask

    // Waits for a result, compares every field, then consumes it.
    task automatic wait_result(input logic [ID_W-1:0] e_id, input logic [7:0] e_max,
                               input logic [7:0] e_min, input logic [7:0] e_mid,
                               input logic [LEN_W-1:0] e_cnt, input string tag);
        int guard;
        guard = 0;
        while (!bus.RES_VALID && guard < 400) begin
            @(negedge CLOCK);
            guard++;
        end
        tests_run++;
        if (!bus.RES_VALID) begin
            tests_failed++;
            $display("FAIL %s: no result within 400 cycles, required RES_VALID", tag);
        end else begin
            if ({bus.RES_ID, bus.RES_MAX, bus.RES_MIN, bus.RES_MID, bus.RES_COUNT} !==
                {e_id, e_max, e_min, e_mid, e_cnt}) begin
                tests_failed++;
                $display("FAIL %s: got id=%0d max=%h min=%h mid=%h cnt=%0d, required id=%0d max=%h min=%h mid=%h cnt=%0d",
                         tag, bus.RES_ID, bus.RES_MAX, bus.RES_MIN, bus.RES_MID, bus.RES_COUNT,
                         e_id, e_max, e_min, e_mid, e_cnt);
            end
            bus.RES_READY = 1'b1;
            @(posedge CLOCK);
            #1 bus.RES_READY = 1'b0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge CLOCK);
        tests_run++;
        if ({bus.GRANT, bus.REQ_READY, bus.BUSY, bus.RES_VALID, bus.RES_ID, bus.RES_MAX,
             bus.RES_MIN, bus.RES_MID, bus.RES_COUNT} !== 41'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: grant=%b ready=%b busy=%b rv=%b, required all zero",
                     bus.GRANT, bus.REQ_READY, bus.BUSY, bus.RES_VALID);
        end
        // RES_READY with no result pending must not change anything.
        bus.RES_READY = 1'b1;
        repeat (2) @(negedge CLOCK);
        tests_run++;
        if ({bus.GRANT, bus.BUSY, bus.RES_VALID} !== 6'd0) begin
            tests_failed++;
            $display("FAIL idle_res_ready: grant=%b busy=%b rv=%b, required all zero",
                     bus.GRANT, bus.BUSY, bus.RES_VALID);
        end
        bus.RES_READY = 1'b0;
    endtask

    task automatic test_basic_stats();
        apply_reset();
        beat_mem[1][0] = 8'h05; beat_mem[1][1] = 8'hF0; beat_mem[1][2] = 8'h7F;
        fork
            drive_session(1, 3, 1'b1);
            wait_result(2'd1, 8'h7F, 8'hF0, 8'h37, 5'd3, "req1_three_beats");
        join
        beat_mem[0][0] = 8'hFF; beat_mem[0][1] = 8'hFE;
        fork
            drive_session(0, 2, 1'b1);
            wait_result(2'd0, 8'hFF, 8'hFE, 8'hFE, 5'd2, "req0_negative_mid");
        join
        beat_mem[0][0] = 8'h80;
        fork
            drive_session(0, 1, 1'b1);
            wait_result(2'd0, 8'h80, 8'h80, 8'h80, 5'd1, "req0_single_beat");
        join
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_grant [0:4];
        logic [ID_W-1:0] exp_id    [0:4];
        logic [NREQ-1:0] prev_grant;
        int n_grant;
        int n_res;
        exp_grant[0] = 4'b0001; exp_grant[1] = 4'b0010; exp_grant[2] = 4'b0100;
        exp_grant[3] = 4'b1000; exp_grant[4] = 4'b0001;
        exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2; exp_id[3] = 2'd3; exp_id[4] = 2'd0;
        apply_reset();
        bus.REQ_DATA  = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.REQ_LAST  = '1;
        bus.REQ_VALID = '1;
        bus.RES_READY = 1'b1;
        prev_grant = '0;
        n_grant = 0;
        n_res = 0;
        for (int cyc = 0; cyc < 40 && n_res < 5; cyc++) begin
            @(negedge CLOCK);
            if (bus.GRANT != '0 && prev_grant == '0 && n_grant < 5) begin
                tests_run++;
                if (bus.GRANT !== exp_grant[n_grant]) begin
                    tests_failed++;
                    $display("FAIL rr_grant_%0d: GRANT=%b, required %b", n_grant, bus.GRANT, exp_grant[n_grant]);
                end
                n_grant++;
            end
            if (bus.RES_VALID) begin
                tests_run++;
                if ({bus.RES_ID, bus.RES_MAX} !== {exp_id[n_res], 8'h10 + 8'(exp_id[n_res])}) begin
                    tests_failed++;
                    $display("FAIL rr_result_%0d: id=%0d max=%h, required id=%0d max=%h", n_res,
                             bus.RES_ID, bus.RES_MAX, exp_id[n_res], 8'h10 + 8'(exp_id[n_res]));
                end
                n_res++;
            end
            prev_grant = bus.GRANT;
        end
        @(posedge CLOCK);
        #1;
        bus.REQ_VALID = '0;
        bus.REQ_LAST  = '0;
        bus.RES_READY = 1'b0;
        tests_run++;
        if (n_grant != 5 || n_res != 5) begin
            tests_failed++;
            $display("FAIL rr_progress: %0d grants %0d results, required 5 and 5", n_grant, n_res);
        end
    endtask

    task automatic test_max_len();
        apply_reset();
        for (int i = 0; i < 16; i++) beat_mem[2][i] = 8'(i * 3 - 20);
        beat_mem[2][16] = 8'h64; beat_mem[2][17] = 8'h9C;
        beat_mem[2][18] = 8'h07; beat_mem[2][19] = 8'h08;
        beat_mem[3][0]  = 8'h33;
        fork
            drive_session(2, 20, 1'b1);
            begin
                int g;
                g = 0;
                while (!bus.GRANT[2] && g < 20) begin
                    @(negedge CLOCK);
                    g++;
                end
                drive_session(3, 1, 1'b1);
            end
            begin
                wait_result(2'd2, 8'h19, 8'hEC, 8'h02, 5'd16, "req2_capped");
                wait_result(2'd3, 8'h33, 8'h33, 8'h33, 5'd1,  "req3_between");
                wait_result(2'd2, 8'h64, 8'h9C, 8'h00, 5'd4,  "req2_remainder");
            end
        join
    endtask

    task automatic test_report_hold();
        int g;
        apply_reset();
        beat_mem[1][0] = 8'h10;
        drive_session(1, 1, 1'b1);
        g = 0;
        while (!bus.RES_VALID && g < 20) begin
            @(negedge CLOCK);
            g++;
        end
        // A competing requester shows up while the result is still pending.
        bus.REQ_VALID[0]  = 1'b1;
        bus.REQ_LAST[0]   = 1'b1;
        bus.REQ_DATA[7:0] = 8'h01;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLOCK);
            tests_run++;
            if ({bus.RES_VALID, bus.RES_ID, bus.RES_MAX, bus.RES_MIN, bus.RES_MID, bus.RES_COUNT,
                 bus.REQ_READY, bus.GRANT} !== {1'b1, 2'd1, 8'h10, 8'h10, 8'h10, 5'd1, 4'b0000, 4'b0010}) begin
                tests_failed++;
                $display("FAIL hold_cycle_%0d: rv=%b id=%0d max=%h cnt=%0d ready=%b grant=%b, required 1 1 10 1 0000 0010",
                         c, bus.RES_VALID, bus.RES_ID, bus.RES_MAX, bus.RES_COUNT, bus.REQ_READY, bus.GRANT);
            end
        end
        bus.RES_READY = 1'b1;
        @(posedge CLOCK);
        #1 bus.RES_READY = 1'b0;
        @(negedge CLOCK);
        tests_run++;
        if ({bus.GRANT, bus.BUSY, bus.RES_VALID} !== 6'd0) begin
            tests_failed++;
            $display("FAIL after_handshake: grant=%b busy=%b rv=%b, required all zero",
                     bus.GRANT, bus.BUSY, bus.RES_VALID);
        end
        @(negedge CLOCK);
        tests_run++;
        if (bus.GRANT !== 4'b0001) begin
            tests_failed++;
            $display("FAIL regrant_latency: GRANT=%b, required 0001", bus.GRANT);
        end
        @(posedge CLOCK);
        #1;
        bus.REQ_VALID[0] = 1'b0;
        bus.REQ_LAST[0]  = 1'b0;
        wait_result(2'd0, 8'h01, 8'h01, 8'h01, 5'd1, "req0_after_hold");
    endtask

    task automatic test_async_reset();
        int k;
        int g;
        apply_reset();
        beat_mem[1][0] = 8'h22;
        fork
            drive_session(1, 1, 1'b1);
            wait_result(2'd1, 8'h22, 8'h22, 8'h22, 5'd1, "req1_before_abort");
        join
        // Pointer now sits at 2. Requester 2 opens a session with no LAST.
        @(posedge CLOCK);
        #1;
        bus.REQ_VALID[2]   = 1'b1;
        bus.REQ_DATA[23:16] = 8'h40;
        k = 0;
        g = 0;
        while (k < 3 && g < 40) begin
            @(negedge CLOCK);
            g++;
            if (bus.REQ_READY[2]) begin
                @(posedge CLOCK);
                #1;
                k++;
                bus.REQ_DATA[23:16] = 8'h40 + 8'(k);
            end
        end
        #1 RESET = 1'b1;
        #1;
        tests_run++;
        if (k != 3 || {bus.GRANT, bus.RES_VALID, bus.BUSY, bus.REQ_READY} !== 10'd0) begin
            tests_failed++;
            $display("FAIL async_reset: beats=%0d grant=%b rv=%b busy=%b ready=%b, required 3 and all zero",
                     k, bus.GRANT, bus.RES_VALID, bus.BUSY, bus.REQ_READY);
        end
        bus.REQ_VALID = '0;
        @(posedge CLOCK);
        #1 RESET = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLOCK);
            tests_run++;
            if (bus.RES_VALID !== 1'b0) begin
                tests_failed++;
                $display("FAIL no_result_after_abort_%0d: RES_VALID=%b, required 0", c, bus.RES_VALID);
            end
        end
        bus.REQ_VALID = 4'b1010;
        bus.REQ_LAST  = 4'b1010;
        g = 0;
        while (bus.GRANT == '0 && g < 10) begin
            @(negedge CLOCK);
            g++;
        end
        tests_run++;
        if (bus.GRANT !== 4'b0010) begin
            tests_failed++;
            $display("FAIL pointer_after_reset: GRANT=%b, required 0010", bus.GRANT);
        end
        bus.REQ_VALID = '0;
        bus.REQ_LAST  = '0;
    endtask

    initial begin
        test_reset();
        test_basic_stats();
        test_round_robin();
        test_max_len();
        test_report_hold();
        test_async_reset();
        apply_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
